// File: rtl/data_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the RISC-V data memory controller:
//   - RV32I load/store funct3 encodings
//   - controller FSM state type
//   - legality helper for funct3 by access direction
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_t;

    // Stores accept only sb/sh/sw; loads additionally accept lbu/lhu.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bus between the LSU (master) and the data memory (slave).
//   req_valid/req_ready : request handshake
//   req_we, req_funct3  : direction and access size/extension
//   req_addr, req_wdata : byte address and store data
//   req_pc              : instruction PC, used only for the store trace
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata, rsp_fault: extended load data and fault flag
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/data_mem_ctrl_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align (combinational)
// Maps a sub-word access onto the four byte lanes of a 32-bit RAM word.
//   addr_lo_i   : byte offset within the word
//   funct3_i    : RV32I load/store size and extension
//   wdata_i     : store data (low bits used for sb/sh)
//   rword_i     : current RAM word
//   byte_en_o   : lanes written by a store
//   wword_o     : store data replicated onto its lanes
//   load_data_o : selected lane(s), sign- or zero-extended
//   misaligned_o: half not on even byte, or word not on word boundary
// -----------------------------------------------------------------------------
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wword_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o
);

    logic [7:0]  lane_byte_s;
    logic [15:0] lane_half_s;

    assign lane_byte_s = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign lane_half_s = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Lane enables, store placement, load extension and alignment by funct3.
    always_comb begin
        byte_en_o    = 4'b0000;
        wword_o      = 32'h0000_0000;
        load_data_o  = 32'h0000_0000;
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_B: begin
                byte_en_o   = 4'b0001 << addr_lo_i;
                wword_o     = {4{wdata_i[7:0]}};
                load_data_o = {{24{lane_byte_s[7]}}, lane_byte_s};
            end
            F3_H: begin
                byte_en_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o      = {2{wdata_i[15:0]}};
                load_data_o  = {{16{lane_half_s[15]}}, lane_half_s};
                misaligned_o = addr_lo_i[0];
            end
            F3_W: begin
                byte_en_o    = 4'b1111;
                wword_o      = wdata_i;
                load_data_o  = rword_i;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            F3_BU: begin
                load_data_o = {24'h00_0000, lane_byte_s};
            end
            F3_HU: begin
                load_data_o  = {16'h0000, lane_half_s};
                misaligned_o = addr_lo_i[0];
            end
            default: begin
                byte_en_o    = 4'b0000;
                wword_o      = 32'h0000_0000;
                load_data_o  = 32'h0000_0000;
                misaligned_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Clocked RISC-V data memory with valid/ready request/response handshake,
// programmable access latency and fault reporting.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high; drops any in-flight request
//   bus   : data_mem_ctrl_if slave (request in, response out)
// Parameters:
//   DEPTH     : number of 32-bit words (power of 2, >= 2)
//   BASE_ADDR : byte address of word 0 (aligned to DEPTH*4)
//   LATENCY   : clock edges from request accept to rsp_valid (>= 1)
//   INIT_FILE : optional initial image name
// -----------------------------------------------------------------------------
module data_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          CW       = $clog2(LATENCY + 1);
    localparam logic [32:0] SPAN     = 33'(DEPTH) * 33'd4;
    localparam logic [CW-1:0] CNT_LAT = CW'(LATENCY);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    dmem_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Request fields captured at accept; the access uses only these.
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;

    logic [31:0] rdata_q;
    logic        fault_q;

    logic [31:0] mem_q [DEPTH];

    logic        req_ready_s;
    logic        rsp_valid_s;
    logic        accept_s;
    logic        access_s;
    logic        mem_we_s;
    logic [31:0] offset_s;
    logic        oor_s;
    logic [AW-1:0] idx_s;
    logic [31:0] rword_s;
    logic [3:0]  byte_en_s;
    logic [31:0] wword_s;
    logic [31:0] load_data_s;
    logic        misaligned_s;
    logic        fault_s;
    logic [31:0] mask_s;
    logic [31:0] merged_s;

    // Offset arithmetic wraps, so addresses below BASE_ADDR land out of range.
    assign offset_s = addr_q - BASE_ADDR;
    assign oor_s    = ({1'b0, offset_s} >= SPAN);
    assign idx_s    = offset_s[AW+1:2];
    assign rword_s  = mem_q[idx_s];

    dmem_lane_align u_align (
        .addr_lo_i    (addr_q[1:0]),
        .funct3_i     (f3_q),
        .wdata_i      (wdata_q),
        .rword_i      (rword_s),
        .byte_en_o    (byte_en_s),
        .wword_o      (wword_s),
        .load_data_o  (load_data_s),
        .misaligned_o (misaligned_s)
    );

    assign fault_s  = misaligned_s | oor_s | ~f3_legal(we_q, f3_q);
    assign mask_s   = {{8{byte_en_s[3]}}, {8{byte_en_s[2]}},
                       {8{byte_en_s[1]}}, {8{byte_en_s[0]}}};
    assign merged_s = (rword_s & ~mask_s) | (wword_s & mask_s);

    assign accept_s = bus.req_valid & req_ready_s;
    assign access_s = (state_q == ACCESS) && (cnt_q == CNT_ONE);
    // Reset on the access edge suppresses the write.
    assign mem_we_s = access_s & we_q & ~fault_s & ~reset;

    // State register, latency counter, latched request and response data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            pc_q    <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_s) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                pc_q    <= bus.req_pc;
            end
            if (access_s) begin
                rdata_q <= (we_q | fault_s) ? 32'h0000_0000 : load_data_s;
                fault_q <= fault_s;
            end
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[idx_s] <= merged_s;
        end
    end

`ifndef SYNTHESIS
    // Store trace line at the committing edge.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            $display("pc = %h: dataaddr = %h, memdata = %h",
                     pc_q, {addr_q[31:2], 2'b00}, merged_s);
        end
    end
`endif

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LAT;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        req_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
        case (state_q)
            IDLE:    req_ready_s = ~reset;
            RESP:    rsp_valid_s = 1'b1;
            default: begin
                req_ready_s = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_fault = fault_q;

endmodule
